// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - fetch/IF-ID stall, redirect and bubble control; optional PIPELINE_PERF_CNT_EN perf counters
module pipeline_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic [31:0] imem_instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc_out,
    output logic [31:0] if_id_instr_out,
    output logic        if_id_valid_out,
    output logic        id_ex_bubble_out,
    output logic [1:0]  state_out,
    output logic        stall_err_out,
    output logic [31:0] stall_cnt_out,
    output logic [31:0] flush_cnt_out
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [8:0] STALL_LIMIT = 9'(MAX_STALL + 1);

    state_t     state;
    logic [7:0] consec_cnt;
    logic [7:0] consec_next;

    assign consec_next      = (consec_cnt == 8'hFF) ? consec_cnt : consec_cnt + 8'd1;
    assign id_ex_bubble_out = stall_in;
    assign state_out        = state;

    // Stall wins over redirect: a branch resolved while stalled is re-presented later by ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out          <= RESET_PC;
            if_id_pc_out    <= 32'h0000_0000;
            if_id_instr_out <= NOP_INSTR;
            if_id_valid_out <= 1'b0;
            state           <= RUN;
            consec_cnt      <= 8'd0;
            stall_err_out   <= 1'b0;
        end else if (stall_in) begin
            state      <= STALL;
            consec_cnt <= consec_next;
            if ({1'b0, consec_next} == STALL_LIMIT) begin
                stall_err_out <= 1'b1;
            end
        end else if (branch_taken_in) begin
            pc_out          <= {branch_target_in[31:2], 2'b00};
            if_id_instr_out <= NOP_INSTR;
            if_id_valid_out <= 1'b0;
            state           <= FLUSH;
            consec_cnt      <= 8'd0;
        end else begin
            pc_out          <= pc_out + 32'd4;
            if_id_pc_out    <= pc_out;
            if_id_instr_out <= imem_instr_in;
            if_id_valid_out <= 1'b1;
            state           <= RUN;
            consec_cnt      <= 8'd0;
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0000_0000;
            flush_cnt <= 32'h0000_0000;
        end else if (stall_in) begin
            if (stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end else if (branch_taken_in) begin
            if (flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_out = stall_cnt;
    assign flush_cnt_out = flush_cnt;
`else
    assign stall_cnt_out = 32'h0000_0000;
    assign flush_cnt_out = 32'h0000_0000;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), giving the bubble inserted into IF/ID.
REQ-003 The module SHALL have parameter MAX_STALL, default 3, giving the maximum legal number of consecutive stall cycles.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port stall_in, input, 1 bit: stall request from the hazard detection unit.
REQ-007 The module SHALL have port branch_taken_in, input, 1 bit: branch or jump resolved taken in ID.
REQ-008 The module SHALL have port branch_target_in, input, 32 bits: redirect address.
REQ-009 The module SHALL have port imem_instr_in, input, 32 bits: instruction fetched at pc_out.
REQ-010 The module SHALL have port pc_out, output, 32 bits: current fetch PC (registered).
REQ-011 The module SHALL have port if_id_pc_out, output, 32 bits: IF/ID PC register.
REQ-012 The module SHALL have port if_id_instr_out, output, 32 bits: IF/ID instruction register.
REQ-013 The module SHALL have port if_id_valid_out, output, 1 bit: IF/ID contents are a real instruction.
REQ-014 The module SHALL have port id_ex_bubble_out, output, 1 bit: zero ID/EX control this cycle; combinational, equal to stall_in.
REQ-015 The module SHALL have port state_out, output, 2 bits: FSM state, RUN=00, STALL=01, FLUSH=10.
REQ-016 The module SHALL have port stall_err_out, output, 1 bit: sticky stall-limit violation.
REQ-017 The module SHALL have ports stall_cnt_out and flush_cnt_out, outputs, 32 bits each: performance counters.

Function
REQ-018 Priority SHALL be reset > stall_in > branch_taken_in > normal advance; branch_taken_in SHALL be ignored in any cycle with stall_in=1.
REQ-019 On a stall (stall_in=1), pc_out, if_id_pc_out, if_id_instr_out and if_id_valid_out SHALL hold their values.
REQ-020 On a redirect (branch_taken_in=1, stall_in=0):
- pc_out <= {branch_target_in[31:2],2'b00}
- if_id_instr_out <= NOP_INSTR
- if_id_valid_out <= 0
- if_id_pc_out holds its value
REQ-021 On normal advance: pc_out <= pc_out+4 (wraps modulo 2^32); if_id_pc_out <= pc_out; if_id_instr_out <= imem_instr_in; if_id_valid_out <= 1.
REQ-022 FSM next state from any state SHALL be: STALL if stall_in; else FLUSH if branch_taken_in; else RUN.
REQ-023 Consecutive-stall counter (8 bits, internal) SHALL increment on each stall cycle, saturate at 255, and clear on any non-stall cycle.
REQ-024 stall_err_out SHALL set at the edge where the counter becomes MAX_STALL+1 and SHALL remain 1 until reset.

Reset
REQ-025 While reset=1 at a rising edge:
- pc_out=RESET_PC, if_id_pc_out=0, if_id_instr_out=NOP_INSTR, if_id_valid_out=0
- state_out=RUN, stall counter=0, stall_err_out=0, stall_cnt_out=0, flush_cnt_out=0
REQ-026 Reset SHALL override stall_in and branch_taken_in in the same cycle, including when asserted mid-stall.

Configuration
REQ-027 With macro PIPELINE_PERF_CNT_EN defined:
- stall_cnt_out SHALL increment on every stall cycle.
- flush_cnt_out SHALL increment on every redirect cycle.
- Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-028 Without PIPELINE_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-029 Release reset with imem_instr_in=32'h00A00093 and no stall -> pc_out 0,4,8; if_id_instr_out=32'h00A00093, if_id_valid_out=1, if_id_pc_out=0 after the second edge.
REQ-030 With pc_out=8, stall_in=1 for 2 cycles -> pc_out stays 8, IF/ID held, id_ex_bubble_out=1, state_out=01, stall_cnt_out+=2, stall_err_out=0.
REQ-031 branch_taken_in=1, branch_target_in=32'h0000_0103, stall_in=0 -> next pc_out=32'h0000_0100, if_id_instr_out=32'h00000013, if_id_valid_out=0, state_out=10, flush_cnt_out+=1.
REQ-032 branch_taken_in=1 and stall_in=1 together -> treated as a stall: PC held, no redirect, flush_cnt_out unchanged.
REQ-033 stall_in held 4 cycles with MAX_STALL=3 -> stall_err_out rises at the 4th edge and stays 1 after stall_in drops.
REQ-034 pc_out=32'hFFFF_FFFC, advance -> pc_out=0; reset asserted mid-stall -> all REQ-025 values on the next edge.
